// File: rtl/raster_pkg.sv
// Shared state encoding and default screen size for the raster bbox front-end.
package raster_pkg;
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SETUP = 2'd1,
    SEQ_LOAD  = 2'd2,
    SEQ_RUN   = 2'd3
  } seq_state_e;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
endpackage

// File: rtl/raster_bbox_clip.sv
// Combinational triangle bounding box, clipped to the screen, with an empty flag.
module raster_bbox_clip
  import raster_pkg::*;
#(
  parameter int XLEN     = 15,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic signed [XLEN:0] i_v0x,
  input  logic signed [XLEN:0] i_v0y,
  input  logic signed [XLEN:0] i_v1x,
  input  logic signed [XLEN:0] i_v1y,
  input  logic signed [XLEN:0] i_v2x,
  input  logic signed [XLEN:0] i_v2y,
  output logic signed [XLEN:0] o_x0,
  output logic signed [XLEN:0] o_x1,
  output logic signed [XLEN:0] o_y0,
  output logic signed [XLEN:0] o_y1,
  output logic                 o_empty
);
  localparam int XW = XLEN + 1;
  localparam logic signed [XLEN:0] X_MAX = XW'(SCREEN_W - 1);
  localparam logic signed [XLEN:0] Y_MAX = XW'(SCREEN_H - 1);

  function automatic logic signed [XLEN:0] min3(input logic signed [XLEN:0] a, b, c);
    logic signed [XLEN:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [XLEN:0] max3(input logic signed [XLEN:0] a, b, c);
    logic signed [XLEN:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic signed [XLEN:0] mnx, mxx, mny, mxy;

  always_comb begin
    mnx = min3(i_v0x, i_v1x, i_v2x);
    mxx = max3(i_v0x, i_v1x, i_v2x);
    mny = min3(i_v0y, i_v1y, i_v2y);
    mxy = max3(i_v0y, i_v1y, i_v2y);
    // Sign bit set means the minimum lies left of / above the screen.
    o_x0 = mnx[XLEN] ? '0 : mnx;
    o_y0 = mny[XLEN] ? '0 : mny;
    o_x1 = (mxx > X_MAX) ? X_MAX : mxx;
    o_y1 = (mxy > Y_MAX) ? Y_MAX : mxy;
    o_empty = (o_x0 > o_x1) || (o_y0 > o_y1);
  end
endmodule

// File: rtl/raster_bbox_sequencer.sv
// Bbox sequencer: accept triangle, clip bbox, load external iterator, stream pixels.
// Optional RASTER_SEQ_STATS_EN adds triangle and pixel handshake counters.
module raster_bbox_sequencer
  import raster_pkg::*;
#(
  parameter int XLEN     = 15,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tri_valid,
  output logic                 o_tri_ready,
  input  logic signed [XLEN:0] i_v0x,
  input  logic signed [XLEN:0] i_v0y,
  input  logic signed [XLEN:0] i_v1x,
  input  logic signed [XLEN:0] i_v1y,
  input  logic signed [XLEN:0] i_v2x,
  input  logic signed [XLEN:0] i_v2y,
  output logic                 o_it_write,
  output logic                 o_it_enable,
  output logic signed [XLEN:0] o_bbx0,
  output logic signed [XLEN:0] o_bbx1,
  output logic signed [XLEN:0] o_bby0,
  output logic signed [XLEN:0] o_bby1,
  input  logic signed [XLEN:0] i_it_x,
  input  logic signed [XLEN:0] i_it_y,
  output logic                 o_px_valid,
  input  logic                 i_px_ready,
  output logic signed [XLEN:0] o_px_x,
  output logic signed [XLEN:0] o_px_y,
  output logic                 o_px_last,
  output logic                 o_busy
`ifdef RASTER_SEQ_STATS_EN
  ,
  output logic [31:0]          o_stat_tris,
  output logic [31:0]          o_stat_px
`endif
);
  seq_state_e state_q, state_d;
  logic [2:0][XLEN:0] vx_q, vx_d, vy_q, vy_d;
  logic signed [XLEN:0] bbx0_q, bbx0_d, bbx1_q, bbx1_d, bby0_q, bby0_d, bby1_q, bby1_d;
  logic tri_ready_q, tri_ready_d, it_write_q, it_write_d;
  logic px_valid_q, px_valid_d, busy_q, busy_d;
  logic signed [XLEN:0] clip_x0, clip_x1, clip_y0, clip_y1;
  logic clip_empty, px_last;

  raster_bbox_clip #(.XLEN(XLEN), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clip (
    .i_v0x(vx_q[0]), .i_v0y(vy_q[0]),
    .i_v1x(vx_q[1]), .i_v1y(vy_q[1]),
    .i_v2x(vx_q[2]), .i_v2y(vy_q[2]),
    .o_x0(clip_x0), .o_x1(clip_x1), .o_y0(clip_y0), .o_y1(clip_y1),
    .o_empty(clip_empty)
  );

  // End of triangle is found by coordinate compare; the iterator's done flag is sticky.
  assign px_last = px_valid_q && (i_it_x == bbx1_q) && (i_it_y == bby1_q);

  always_comb begin
    state_d     = state_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    bbx0_d      = bbx0_q;
    bbx1_d      = bbx1_q;
    bby0_d      = bby0_q;
    bby1_d      = bby1_q;
    tri_ready_d = 1'b0;
    it_write_d  = 1'b0;
    px_valid_d  = 1'b0;
    busy_d      = 1'b1;
    case (state_q)
      SEQ_IDLE: begin
        tri_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (i_tri_valid) begin
          vx_d        = {i_v2x, i_v1x, i_v0x};
          vy_d        = {i_v2y, i_v1y, i_v0y};
          state_d     = SEQ_SETUP;
          tri_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      SEQ_SETUP: begin
        bbx0_d = clip_x0;
        bbx1_d = clip_x1;
        bby0_d = clip_y0;
        bby1_d = clip_y1;
        if (clip_empty) begin
          state_d     = SEQ_IDLE;
          tri_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d    = SEQ_LOAD;
          it_write_d = 1'b1;
        end
      end
      SEQ_LOAD: begin
        state_d    = SEQ_RUN;
        px_valid_d = 1'b1;
      end
      SEQ_RUN: begin
        px_valid_d = 1'b1;
        if (i_px_ready && px_last) begin
          state_d     = SEQ_IDLE;
          px_valid_d  = 1'b0;
          tri_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= SEQ_IDLE;
      vx_q        <= '0;
      vy_q        <= '0;
      bbx0_q      <= '0;
      bbx1_q      <= '0;
      bby0_q      <= '0;
      bby1_q      <= '0;
      tri_ready_q <= 1'b1;
      it_write_q  <= 1'b0;
      px_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      bbx0_q      <= bbx0_d;
      bbx1_q      <= bbx1_d;
      bby0_q      <= bby0_d;
      bby1_q      <= bby1_d;
      tri_ready_q <= tri_ready_d;
      it_write_q  <= it_write_d;
      px_valid_q  <= px_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_tri_ready = tri_ready_q;
  assign o_it_write  = it_write_q;
  assign o_it_enable = px_valid_q & i_px_ready & ~px_last;
  assign o_bbx0      = bbx0_q;
  assign o_bbx1      = bbx1_q;
  assign o_bby0      = bby0_q;
  assign o_bby1      = bby1_q;
  assign o_px_valid  = px_valid_q;
  assign o_px_x      = px_valid_q ? i_it_x : '0;
  assign o_px_y      = px_valid_q ? i_it_y : '0;
  assign o_px_last   = px_last;
  assign o_busy      = busy_q;

`ifdef RASTER_SEQ_STATS_EN
  logic [31:0] stat_tris_q, stat_tris_d, stat_px_q, stat_px_d;

  always_comb begin
    stat_tris_d = stat_tris_q + ((state_q == SEQ_IDLE && i_tri_valid) ? 32'd1 : 32'd0);
    stat_px_d   = stat_px_q + ((px_valid_q && i_px_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stat_tris_q <= '0;
      stat_px_q   <= '0;
    end else begin
      stat_tris_q <= stat_tris_d;
      stat_px_q   <= stat_px_d;
    end
  end

  assign o_stat_tris = stat_tris_q;
  assign o_stat_px   = stat_px_q;
`endif
endmodule

// File: tb/tb_raster_bbox_sequencer.sv
// Bench for raster_bbox_sequencer: bench-side iterator, expected-pixel queue model, directed triangles.
module tb_raster_bbox_sequencer;
  localparam int SW = 320;
  localparam int SH = 240;

  typedef struct { int x; int y; bit last; } px_t;

  logic i_clk = 1'b0, i_reset = 1'b1, i_tri_valid = 1'b0, i_px_ready = 1'b1;
  logic signed [15:0] v0x = 0, v0y = 0, v1x = 0, v1y = 0, v2x = 0, v2y = 0;
  logic signed [15:0] it_x = 0, it_y = 0;
  logic o_tri_ready, o_it_write, o_it_enable, o_px_valid, o_px_last, o_busy;
  logic signed [15:0] o_bbx0, o_bbx1, o_bby0, o_bby1, o_px_x, o_px_y;
`ifdef RASTER_SEQ_STATS_EN
  logic [31:0] o_stat_tris, o_stat_px;
`endif

  raster_bbox_sequencer #(.XLEN(15), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tri_valid(i_tri_valid), .o_tri_ready(o_tri_ready),
    .i_v0x(v0x), .i_v0y(v0y), .i_v1x(v1x), .i_v1y(v1y), .i_v2x(v2x), .i_v2y(v2y),
    .o_it_write(o_it_write), .o_it_enable(o_it_enable),
    .o_bbx0(o_bbx0), .o_bbx1(o_bbx1), .o_bby0(o_bby0), .o_bby1(o_bby1),
    .i_it_x(it_x), .i_it_y(it_y), .o_px_valid(o_px_valid), .i_px_ready(i_px_ready),
    .o_px_x(o_px_x), .o_px_y(o_px_y), .o_px_last(o_px_last), .o_busy(o_busy)
`ifdef RASTER_SEQ_STATS_EN
    , .o_stat_tris(o_stat_tris), .o_stat_px(o_stat_px)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, acc_cyc = 0, px_cnt = 0, wr_cnt = 0, neg_cnt = 0, last_cnt = 0;
  bit first_pend = 0, last_hs = 0, tog = 0;
  int pidx = 0;
  px_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // External iterator: load on write, step raster order on enable.
  always @(posedge i_clk) begin
    if (o_it_write) begin
      it_x <= o_bbx0;
      it_y <= o_bby0;
    end else if (o_it_enable) begin
      if (it_x == o_bbx1) begin
        it_x <= o_bbx0;
        it_y <= it_y + 16'sd1;
      end else it_x <= it_x + 16'sd1;
    end
  end

  // Downstream backpressure: ready pattern 1,0,0,1 when toggling, else always ready.
  always @(posedge i_clk) begin
    #1;
    if (tog) begin
      i_px_ready = (pidx == 0 || pidx == 3);
      pidx = (pidx + 1) % 4;
    end else i_px_ready = 1'b1;
  end

  // Per-cycle compare against the expected pixel queue.
  always @(negedge i_clk) begin
    px_t e;
    chk("busy_vs_ready", int'(o_busy), int'(!o_tri_ready));
    if (last_hs) begin
      chk("ready_after_last", int'(o_tri_ready), 1);
      last_hs = 0;
    end
    if (o_it_write) wr_cnt++;
    if (!o_px_valid) begin
      if (o_it_enable) chk("enable_while_idle", 1, 0);
    end else begin
      if (first_pend) begin
        chk("first_px_latency", cyc - acc_cyc, 3);
        first_pend = 0;
      end
      if (o_px_x < 0 || o_px_y < 0) neg_cnt++;
      if (exp_q.size() == 0) chk("unexpected_pixel", 1, 0);
      else begin
        e = exp_q[0];
        chk("px_x", int'(o_px_x), e.x);
        chk("px_y", int'(o_px_y), e.y);
        chk("px_last", int'(o_px_last), int'(e.last));
        chk("it_enable", int'(o_it_enable), int'(i_px_ready && !e.last));
        if (i_px_ready) begin
          void'(exp_q.pop_front());
          px_cnt++;
          if (e.last) begin
            last_cnt++;
            last_hs = 1;
          end
        end
      end
    end
  end

  // Expected stream from the triangle: clipped min/max box, raster order.
  task automatic build(input int ax, ay, bx, by, cx, cy, output int n, output bit cull);
    int x0, x1, y0, y1, t;
    x0 = ax; if (bx < x0) x0 = bx; if (cx < x0) x0 = cx;
    x1 = ax; if (bx > x1) x1 = bx; if (cx > x1) x1 = cx;
    y0 = ay; if (by < y0) y0 = by; if (cy < y0) y0 = cy;
    y1 = ay; if (by > y1) y1 = by; if (cy > y1) y1 = cy;
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    if (x1 > SW - 1) x1 = SW - 1;
    if (y1 > SH - 1) y1 = SH - 1;
    cull = (x0 > x1) || (y0 > y1);
    n = 0;
    if (!cull)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++) begin
          px_t p;
          p.x = x; p.y = y; p.last = (x == x1 && y == y1);
          t = n; n = t + 1;
          exp_q.push_back(p);
        end
  endtask

  task automatic start_tri(input int ax, ay, bx, by, cx, cy, output int n, output bit cull);
    bit got;
    build(ax, ay, bx, by, cx, cy, n, cull);
    px_cnt = 0; neg_cnt = 0; last_cnt = 0;
    @(posedge i_clk); #1;
    v0x = 16'(ax); v0y = 16'(ay); v1x = 16'(bx); v1y = 16'(by); v2x = 16'(cx); v2y = 16'(cy);
    i_tri_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge i_clk);
      if (o_tri_ready) begin
        got = 1;
        acc_cyc = cyc;
        first_pend = !cull;
      end
    end
    @(posedge i_clk); #1;
    i_tri_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_tri(input int ax, ay, bx, by, cx, cy, input bit toggle, input int lit_n);
    int n, w0;
    bit cull, done;
    w0 = wr_cnt;
    tog = toggle; pidx = 0;
    start_tri(ax, ay, bx, by, cx, cy, n, cull);
    chk("model_count", n, lit_n);
    if (cull) begin
      @(negedge i_clk);
      chk("cull_setup_ready", int'(o_tri_ready), 0);
      @(negedge i_clk);
      chk("cull_ready_back", int'(o_tri_ready), 1);
      chk("cull_ready_delay", cyc - acc_cyc, 2);
      repeat (4) @(negedge i_clk);
      chk("cull_no_write", wr_cnt - w0, 0);
    end else begin
      done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
        @(negedge i_clk);
        done = o_tri_ready && exp_q.size() == 0;
      end
      if (!done) chk("tri_done_timeout", 0, 1);
      chk("one_write", wr_cnt - w0, 1);
      chk("last_count", last_cnt, 1);
    end
    chk("px_count", px_cnt, lit_n);
    exp_q.delete();
    first_pend = 0;
    tog = 0;
  endtask

  initial begin
    int n;
    bit cull, hit;
    repeat (3) @(negedge i_clk);
    chk("rst_tri_ready", int'(o_tri_ready), 1);
    chk("rst_px_valid", int'(o_px_valid), 0);
    chk("rst_it_write", int'(o_it_write), 0);
    chk("rst_it_enable", int'(o_it_enable), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_bbx1", int'(o_bbx1), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    run_tri(2, 3, 5, 3, 2, 4, 0, 8);
    chk("t1_bbx0", int'(o_bbx0), 2);
    chk("t1_bbx1", int'(o_bbx1), 5);
    chk("t1_bby0", int'(o_bby0), 3);
    chk("t1_bby1", int'(o_bby1), 4);

    run_tri(-10, -5, 4, -2, 1, 1, 0, 10);
    chk("t2_bbx0", int'(o_bbx0), 0);
    chk("t2_bbx1", int'(o_bbx1), 4);
    chk("t2_bby0", int'(o_bby0), 0);
    chk("t2_bby1", int'(o_bby1), 1);
    chk("t2_no_negative", neg_cnt, 0);

    run_tri(400, 10, 420, 12, 410, 30, 0, 0);

    run_tri(7, 7, 7, 7, 7, 7, 0, 1);

    run_tri(2, 3, 5, 3, 2, 4, 1, 8);

    // Reset on the third pixel of a 4x4 box.
    start_tri(0, 0, 3, 0, 0, 3, n, cull);
    chk("t6_model_count", n, 16);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge i_clk); #1;
      if (px_cnt == 2) hit = 1;
    end
    if (!hit) chk("t6_third_px_timeout", 0, 1);
    chk("t6_third_valid", int'(o_px_valid), 1);
    chk("t6_third_x", int'(o_px_x), 2);
    i_reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("t6_rst_valid", int'(o_px_valid), 0);
    chk("t6_rst_ready", int'(o_tri_ready), 1);
    chk("t6_rst_busy", int'(o_busy), 0);
    chk("t6_rst_bbx1", int'(o_bbx1), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    exp_q.delete();
    first_pend = 0;

    run_tri(0, 0, 1, 0, 0, 1, 0, 4);

    repeat (3) @(negedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/raster_bbox_sequencer.md
Name: raster_bbox_sequencer

Overview:
Front-end controller for the bounding-box pixel iterator.
- Accepts one triangle (three signed vertices) per command handshake.
- Computes the bounding box and clips it to the screen; if the clipped box is empty, the triangle is dropped.
- Loads the iterator, then steps it under downstream backpressure and emits a pixel stream with a last-pixel flag.
- Sits between the triangle setup stage and the edge-function/shading pipeline.

Parameters:
XLEN, 15, coordinate MSB index; all coordinates are signed [XLEN:0]
SCREEN_W, 320, screen width in pixels; x clip range is [0, SCREEN_W-1]
SCREEN_H, 240, screen height in pixels; y clip range is [0, SCREEN_H-1]

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_tri_valid  in  1  triangle command valid
o_tri_ready  out  1  sequencer can accept a triangle
i_v0x,i_v0y,i_v1x,i_v1y,i_v2x,i_v2y  in  XLEN+1 each  signed vertex coordinates
o_it_write  out  1  iterator load strobe
o_it_enable  out  1  iterator step strobe
o_bbx0,o_bbx1,o_bby0,o_bby1  out  XLEN+1 each  clipped box driven to the iterator
i_it_x,i_it_y  in  XLEN+1 each  current iterator coordinate
o_px_valid  out  1  pixel valid
i_px_ready  in  1  downstream accepts pixel
o_px_x,o_px_y  out  XLEN+1 each  pixel coordinate
o_px_last  out  1  last pixel of the triangle
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs are 0, except o_tri_ready=1 (IDLE). Bbox registers are cleared. A reset asserted in any state returns the block to IDLE on the next edge and discards any triangle in flight.
- States: IDLE, SETUP, LOAD, RUN.
- IDLE:
  - o_tri_ready=1.
  - On i_tri_valid, latch the vertices and go to SETUP.
- SETUP (1 cycle):
  - Compute the signed min/max of the three x and three y values.
  - Clip: x0=max(minx,0), x1=min(maxx,SCREEN_W-1); same for y with SCREEN_H.
  - Register the results onto o_bb*.
  - If x0>x1 or y0>y1 (signed compare), the triangle is culled: go to IDLE and emit no pixels. Otherwise go to LOAD.
- LOAD (1 cycle):
  - Pulse o_it_write=1; the iterator presents (x0,y0) on the next cycle.
  - Go to RUN.
- RUN:
  - o_px_valid=1, with o_px_x/o_px_y = i_it_x/i_it_y passed straight through.
  - o_px_last = (i_it_x==o_bbx1) && (i_it_y==o_bby1).
  - o_it_enable = o_px_valid & i_px_ready & ~o_px_last (combinational). This gives 1 pixel/clk when not stalled.
  - While i_px_ready is low, the coordinate and valid are held and o_it_enable=0.
  - On a handshake with o_px_last=1, go to IDLE.
- The iterator's done output is not used; it is sticky across loads. End of triangle is detected only by coordinate compare.
- Pixels per triangle = (x1-x0+1)*(y1-y0+1), in raster order: x fastest, then y.
- Triangle latency: accept to first o_px_valid is 3 cycles (SETUP, LOAD, RUN). o_tri_ready next rises the cycle after the last handshake.
- A single-pixel box asserts o_px_last together with the first valid.

Optional Feature:
RASTER_SEQ_STATS_EN
- Defined: adds two 32-bit output ports, both cleared by reset and wrapping on overflow.
  - o_stat_tris counts accepted triangles, including culled ones.
  - o_stat_px counts pixel handshakes.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package raster_pkg holds:
  - state encoding constants SEQ_IDLE, SEQ_SETUP, SEQ_LOAD, SEQ_RUN;
  - default screen dimension constants.
- One sub-module, raster_bbox_clip: combinational min3/max3 plus clipping and an empty flag, instantiated in SETUP.
- The iterator is instantiated externally, beside the sequencer.

Test Plan:
- Triangle (2,3),(5,3),(2,4) with i_px_ready=1 → 8 pixels in order (2,3)..(5,3),(2,4)..(5,4); last only on (5,4); first valid 3 cycles after accept.
- Triangle (-10,-5),(4,-2),(1,1) → clipped box x 0..4, y 0..1; 10 pixels, none with a negative coordinate.
- Triangle fully off-screen (400,10),(420,12),(410,30) with SCREEN_W=320 → culled; no o_it_write, no pixels; o_tri_ready back high 2 cycles after accept.
- Degenerate triangle, all vertices (7,7) → exactly one pixel (7,7) with o_px_last=1.
- Same box as the first test, with i_px_ready toggling 1,0,0,1 repeatedly → coordinates held during stalls, no o_it_enable while ready=0, same 8-pixel sequence.
- Assert i_reset on the 3rd pixel of a 4x4 box → next cycle IDLE, o_px_valid=0, o_tri_ready=1; a following triangle (0,0),(1,0),(0,1) → exactly 4 correct pixels.
